// File: rtl/cellram_pkg.sv
// Shared definitions for the cell-RAM bus so the arbitrator and the responder
// agree on widths, state encoding and default timing.
package cellram_pkg;

   localparam int MEM_ADDR_W = 23;
   localparam int MEM_DATA_W = 16;

   localparam int DEF_LATENCY     = 3;
   localparam int DEF_ROW_WORDS   = 128;
   localparam int DEF_ROW_PENALTY = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAT,
      ST_DATA,
      ST_ROWWAIT
   } cellram_state_t;

endpackage

// File: rtl/cellram_storage.sv
// Single-port synchronous RAM with write enable and a registered read port,
// written so synthesis maps it onto a block RAM.
module cellram_storage #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/cellram_responder.sv
// Memory-side end of the cell-RAM bus: latches a burst address, applies the
// initial latency and row-crossing penalties, then moves one word per cycle.
module cellram_responder
   import cellram_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int LATENCY     = DEF_LATENCY,
   parameter int ROW_WORDS   = DEF_ROW_WORDS,
   parameter int ROW_PENALTY = DEF_ROW_PENALTY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic                  mem_addr_valid,
   input  logic                  mem_we,
   input  logic                  mem_oe,
   inout  wire  [MEM_DATA_W-1:0] mem_data,
   output logic                  mem_wait,
   output logic                  busy,
   output logic [31:0]           beat_count
);

   localparam logic [ADDR_WIDTH-1:0] ROW_MASK = ADDR_WIDTH'(ROW_WORDS - 1);
   localparam logic [7:0]            LAT_LOAD = 8'(LATENCY - 1);
   localparam logic [7:0]            PEN_LOAD = 8'(ROW_PENALTY - 1);

   cellram_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0]   addr, addr_next, addr_inc;
   logic                    dir_write, dir_next;
   logic [7:0]              wait_cnt, cnt_next;
   logic                    beat, strobe;
   logic                    ram_we;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic [MEM_DATA_W-1:0]   rdata;

   generate
      if (ADDR_WIDTH < MEM_ADDR_W) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^mem_addr[MEM_ADDR_W-1:ADDR_WIDTH];
      end
   endgenerate

   assign addr_inc = addr + 1'b1;
   assign strobe   = dir_write ? mem_we : mem_oe;

   // A read beat prefetches the following word so it is on the bus next cycle;
   // in every other state the RAM simply re-reads the current address.
   always_comb begin
      state_next = state;
      addr_next  = addr;
      dir_next   = dir_write;
      cnt_next   = wait_cnt;
      beat       = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr;
      unique case (state)
         ST_IDLE: begin
            if (mem_addr_valid) begin
               addr_next  = mem_addr[ADDR_WIDTH-1:0];
               dir_next   = mem_we;
               cnt_next   = LAT_LOAD;
               state_next = ST_LAT;
            end
         end
         ST_LAT, ST_ROWWAIT: begin
            if (wait_cnt == 8'd0) begin
               state_next = ST_DATA;
            end else begin
               cnt_next = wait_cnt - 8'd1;
            end
         end
         ST_DATA: begin
            if (mem_addr_valid) begin
               addr_next  = mem_addr[ADDR_WIDTH-1:0];
               dir_next   = mem_we;
               cnt_next   = LAT_LOAD;
               state_next = ST_LAT;
            end else if (strobe) begin
               beat      = 1'b1;
               addr_next = addr_inc;
               ram_we    = dir_write;
               if (!dir_write) begin
                  ram_addr = addr_inc;
               end
               if (ROW_PENALTY > 0 && (addr_inc & ROW_MASK) == '0) begin
                  cnt_next   = PEN_LOAD;
                  state_next = ST_ROWWAIT;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         addr       <= '0;
         dir_write  <= 1'b0;
         wait_cnt   <= 8'd0;
         beat_count <= 32'd0;
      end else begin
         state     <= state_next;
         addr      <= addr_next;
         dir_write <= dir_next;
         wait_cnt  <= cnt_next;
         if (beat) begin
            beat_count <= beat_count + 32'd1;
         end
      end
   end

   cellram_storage #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (MEM_DATA_W)
   ) u_storage (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (mem_data),
      .rdata (rdata)
   );

   assign mem_wait = (state == ST_LAT) || (state == ST_ROWWAIT);
   assign busy     = (state != ST_IDLE);
   assign mem_data = (state == ST_DATA && !dir_write && mem_oe) ? rdata : {MEM_DATA_W{1'bz}};

endmodule

// File: tb/tb_cellram_responder.sv
// Randomised and directed bench for cellram_responder against a word-level
// model of bursts, wait cycles and the beat counter.
module tb_cellram_responder;

   localparam int AW    = 12;
   localparam int LAT   = 3;
   localparam int RW    = 128;
   localparam int PEN   = 2;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        reset;
   logic [22:0] mem_addr;
   logic        mem_addr_valid;
   logic        mem_we;
   logic        mem_oe;
   wire  [15:0] mem_data;
   logic        mem_wait;
   logic        busy;
   logic [31:0] beat_count;

   logic        tb_drive;
   logic [15:0] tb_data;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: memory image plus the visible burst situation
   logic [15:0] ref_mem   [DEPTH];
   bit          ref_known [DEPTH];
   bit          m_active;
   bit          m_write;
   int          m_wait;
   int          m_addr;
   logic [31:0] m_count;
   logic [15:0] burst_data [16];

   assign mem_data = tb_drive ? tb_data : 16'bz;

   always #5 clk = ~clk;

   cellram_responder #(
      .ADDR_WIDTH  (AW),
      .LATENCY     (LAT),
      .ROW_WORDS   (RW),
      .ROW_PENALTY (PEN)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_addr_valid (mem_addr_valid),
      .mem_we         (mem_we),
      .mem_oe         (mem_oe),
      .mem_data       (mem_data),
      .mem_wait       (mem_wait),
      .busy           (busy),
      .beat_count     (beat_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit av, input logic [22:0] a,
                             input bit we, input bit oe, input logic [15:0] d);
      if (!rst_n) begin
         m_active = 1'b0;
         m_wait   = 0;
         m_count  = 32'd0;
      end else if (av && (!m_active || m_wait == 0)) begin
         m_active = 1'b1;
         m_write  = we;
         m_addr   = int'(a[AW-1:0]);
         m_wait   = LAT;
      end else if (m_active && m_wait > 0) begin
         m_wait--;
      end else if (m_active) begin
         if (!(m_write ? we : oe)) begin
            m_active = 1'b0;
         end else begin
            if (m_write) begin
               ref_mem[m_addr]   = d;
               ref_known[m_addr] = 1'b1;
            end
            m_addr  = (m_addr + 1) % DEPTH;
            m_count = m_count + 32'd1;
            if (PEN > 0 && (m_addr % RW) == 0) m_wait = PEN;
         end
      end
   endtask

   // One bus cycle: drive after the falling edge, check, clock, advance the model
   task automatic applyStimulus(input bit rst_n, input bit av, input logic [22:0] a,
                                input bit we, input bit oe, input logic [15:0] d);
      bit expect_drive;
      reset          = rst_n;
      mem_addr_valid = av;
      mem_addr       = a;
      mem_we         = we;
      mem_oe         = oe;
      expect_drive   = m_active && m_wait == 0 && !m_write && oe;
      tb_drive       = !expect_drive;
      tb_data        = d;
      #1;
      checkOutput("mem_wait", 32'(mem_wait), 32'(m_active && m_wait > 0));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("beat_count", beat_count, m_count);
      if (expect_drive) begin
         if (ref_known[m_addr]) checkOutput("rd_data", 32'(mem_data), 32'(ref_mem[m_addr]));
      end else begin
         checkOutput("bus_released", 32'(mem_data), 32'(d));
      end
      @(posedge clk);
      model_step(rst_n, av, a, we, oe, d);
      @(negedge clk);
   endtask

   task automatic run_burst(input bit wr, input logic [22:0] a, input int n);
      applyStimulus(1'b1, 1'b1, a, wr, 1'b0, 16'($urandom));
      repeat (LAT) applyStimulus(1'b1, 1'b0, 23'd0, wr, !wr, 16'($urandom));
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 23'd0, wr, !wr, burst_data[i]);
      applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'($urandom));
   endtask

   initial begin
      logic [22:0] last_wr_addr;
      last_wr_addr   = 23'h010;
      reset          = 1'b0;
      mem_addr_valid = 1'b0;
      mem_addr       = 23'd0;
      mem_we         = 1'b0;
      mem_oe         = 1'b0;
      tb_drive       = 1'b1;
      tb_data        = 16'h5A5A;
      m_active       = 1'b0;
      m_write        = 1'b0;
      m_wait         = 0;
      m_addr         = 0;
      m_count        = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_wait", 32'(mem_wait), 32'd0);
      checkOutput("reset_count", beat_count, 32'd0);

      burst_data[0] = 16'h1111; burst_data[1] = 16'h2222; burst_data[2] = 16'h3333;
      run_burst(1'b1, 23'h010, 3);
      checkOutput("wr_burst_count", beat_count, 32'd3);
      checkOutput("wr_burst_busy", 32'(busy), 32'd0);
      run_burst(1'b0, 23'h010, 3);
      checkOutput("rd_burst_count", beat_count, 32'd6);

      burst_data[0] = 16'h00A0; burst_data[1] = 16'h00A1; burst_data[2] = 16'h00A2;
      burst_data[3] = 16'h00A2; burst_data[4] = 16'h00A2; burst_data[5] = 16'h00A3;
      run_burst(1'b1, 23'h07E, 6);
      checkOutput("row_wr_count", beat_count, 32'd10);
      run_burst(1'b0, 23'h07E, 6);
      checkOutput("row_rd_count", beat_count, 32'd14);

      for (int i = 0; i < 3; i++) burst_data[i] = 16'($urandom);
      run_burst(1'b1, 23'h200, 3);
      applyStimulus(1'b1, 1'b1, 23'h010, 1'b0, 1'b0, 16'($urandom));
      repeat (LAT) applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b1, 16'($urandom));
      applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b1, 16'($urandom));
      applyStimulus(1'b1, 1'b1, 23'h200, 1'b0, 1'b1, 16'($urandom));
      checkOutput("abort_no_beat", beat_count, 32'd18);
      repeat (LAT) applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b1, 16'($urandom));
      repeat (2) applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b1, 16'($urandom));
      applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'($urandom));
      checkOutput("abort_count", beat_count, 32'd20);

      applyStimulus(1'b1, 1'b1, 23'h300, 1'b1, 1'b0, 16'($urandom));
      repeat (LAT) applyStimulus(1'b1, 1'b0, 23'd0, 1'b1, 1'b0, 16'($urandom));
      applyStimulus(1'b1, 1'b0, 23'd0, 1'b1, 1'b0, 16'hC0DE);
      applyStimulus(1'b1, 1'b0, 23'd0, 1'b1, 1'b0, 16'hBEEF);
      applyStimulus(1'b0, 1'b0, 23'd0, 1'b1, 1'b0, 16'hDEAD);
      checkOutput("rst_mid_count", beat_count, 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_wait", 32'(mem_wait), 32'd0);
      run_burst(1'b0, 23'h300, 2);

      burst_data[0] = 16'h00B0; burst_data[1] = 16'h00B1;
      burst_data[2] = 16'h00B1; burst_data[3] = 16'h00B1;
      run_burst(1'b1, 23'h7FFFFF, 4);
      checkOutput("wrap_wr_count", beat_count, 32'd4);
      run_burst(1'b0, 23'h000FFF, 4);
      checkOutput("wrap_rd_count", beat_count, 32'd6);

      // Random bursts biased towards row ends and previously written areas
      for (int b = 0; b < 80; b++) begin
         bit          wr;
         logic [22:0] a;
         int          n;
         wr = ($urandom_range(0, 1) == 1);
         a  = 23'($urandom);
         if (!wr && $urandom_range(0, 1) == 1) a = last_wr_addr;
         else if ($urandom_range(0, 1) == 1) a[6:0] = 7'(128 - $urandom_range(1, 3));
         if (wr) last_wr_addr = a;
         applyStimulus(1'b1, 1'b1, a, wr, ($urandom_range(0, 1) == 1), 16'($urandom));
         n = $urandom_range(4, 16);
         for (int c = 0; c < n; c++) begin
            bit strobe, other, rst_n, av;
            strobe = ($urandom_range(0, 9) != 0);
            other  = ($urandom_range(0, 1) == 1);
            rst_n  = ($urandom_range(0, 99) != 0);
            av     = ($urandom_range(0, 29) == 0);
            applyStimulus(rst_n, av, 23'($urandom), wr ? strobe : other, wr ? other : strobe,
                          16'($urandom));
         end
         applyStimulus(1'b1, 1'b0, 23'd0, 1'b0, 1'b0, 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
